tx_deframer: RTL

TX_DEFRAMER -- requirements
Module: tx_deframer

---
 rtl/tx_deframer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/tx_deframer.sv
// tx_deframer: pulls 3-byte frames {header, MSB, LSB} out of an upstream FIFO,
// checks the header sync nibble, and presents the reassembled 16-bit word plus
// its channel index on a hold-until-accepted output. Bad headers are skipped
// one byte at a time; a frame that stalls too long mid-way is abandoned.
module tx_deframer #(
  parameter logic [3:0]  SYNC    = 4'hA,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rdata,
  input  logic        rempty,
  output logic        rinc,
  output logic [15:0] out_data,
  output logic [1:0]  out_chan,
  output logic        out_avail,
  input  logic        out_accept,
  output logic        sync_err,
  output logic [7:0]  err_count
);

  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_MSB  = 2'd1,
    S_LSB  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic [1:0]  r_rstSync;
  logic        w_ready;

  logic [15:0] r_tcnt;
  logic [15:0] w_tcntNext;
  logic [15:0] w_tcntInc;

  logic [1:0]  r_hdrChan;
  logic [7:0]  r_msb;
  logic [15:0] r_outData;
  logic [1:0]  r_outChan;
  logic        r_outAvail;
  logic        w_availNext;
  logic        r_syncErr;
  logic [7:0]  r_errCount;

  logic        w_pop;
  logic        w_hdrOk;
  logic        w_idle;
  logic        w_expired;
  logic        w_errEvent;
  logic        w_latchChan;
  logic        w_latchMsb;
  logic        w_loadOut;

  // Reset release is retimed through two flops so the FSM starts on a clean edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstSync <= 2'b00;
    end else begin
      r_rstSync <= {r_rstSync[0], 1'b1};
    end
  end

  assign w_ready = r_rstSync[1];

  // A byte is popped whenever one is available and the FSM is not holding a word
  assign w_pop     = w_ready && !rempty && (r_state != S_HOLD);
  assign rinc      = w_pop;
  assign w_hdrOk   = (rdata[7:4] == SYNC) && (rdata[3:2] == 2'b00);
  assign w_idle    = w_ready && rempty;
  assign w_tcntInc = r_tcnt + 16'd1;
  assign w_expired = (w_tcntInc == LP_TIMEOUT);

  // Next-state, timeout counter and datapath load strobes
  always_comb begin
    w_stateNext = r_state;
    w_tcntNext  = r_tcnt;
    w_availNext = r_outAvail;
    w_errEvent  = 1'b0;
    w_latchChan = 1'b0;
    w_latchMsb  = 1'b0;
    w_loadOut   = 1'b0;
    case (r_state)
      S_HDR: begin
        w_tcntNext = 16'd0;
        if (w_pop) begin
          if (w_hdrOk) begin
            w_latchChan = 1'b1;
            w_stateNext = S_MSB;
          end else begin
            w_errEvent = 1'b1;
          end
        end
      end
      S_MSB: begin
        if (w_pop) begin
          w_latchMsb  = 1'b1;
          w_tcntNext  = 16'd0;
          w_stateNext = S_LSB;
        end else if (w_idle) begin
          if (w_expired) begin
            w_errEvent  = 1'b1;
            w_tcntNext  = 16'd0;
            w_stateNext = S_HDR;
          end else begin
            w_tcntNext = w_tcntInc;
          end
        end
      end
      S_LSB: begin
        if (w_pop) begin
          w_loadOut   = 1'b1;
          w_availNext = 1'b1;
          w_tcntNext  = 16'd0;
          w_stateNext = S_HOLD;
        end else if (w_idle) begin
          if (w_expired) begin
            w_errEvent  = 1'b1;
            w_tcntNext  = 16'd0;
            w_stateNext = S_HDR;
          end else begin
            w_tcntNext = w_tcntInc;
          end
        end
      end
      S_HOLD: begin
        w_tcntNext = 16'd0;
        if (out_accept) begin
          w_availNext = 1'b0;
          w_stateNext = S_HDR;
        end
      end
      default: begin
        w_stateNext = S_HDR;
        w_availNext = 1'b0;
        w_tcntNext  = 16'd0;
      end
    endcase
  end

  // FSM state and timeout counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HDR;
      r_tcnt  <= 16'd0;
    end else begin
      r_state <= w_stateNext;
      r_tcnt  <= w_tcntNext;
    end
  end

  // Frame field capture; the output word only changes when a full frame lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdrChan  <= 2'b00;
      r_msb      <= 8'h00;
      r_outData  <= 16'h0000;
      r_outChan  <= 2'b00;
      r_outAvail <= 1'b0;
    end else begin
      if (w_latchChan) begin
        r_hdrChan <= rdata[1:0];
      end
      if (w_latchMsb) begin
        r_msb <= rdata;
      end
      if (w_loadOut) begin
        r_outData <= {r_msb, rdata};
        r_outChan <= r_hdrChan;
      end
      r_outAvail <= w_availNext;
    end
  end

  // Error pulse and saturating error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_syncErr  <= 1'b0;
      r_errCount <= 8'h00;
    end else begin
      r_syncErr <= w_errEvent;
      if (w_errEvent && (r_errCount != 8'hFF)) begin
        r_errCount <= r_errCount + 8'd1;
      end
    end
  end

  assign out_data  = r_outData;
  assign out_chan  = r_outChan;
  assign out_avail = r_outAvail;
  assign sync_err  = r_syncErr;
  assign err_count = r_errCount;

endmodule
